rf_access_sched: RTL and testbench

Scheduler that shares the 32×64-bit register file (2 write ports, 4 read ports) among four requesters. Each requester issues single read or write requests over a valid/ready handshake. The block drives the register file's enable/address/data controls and returns read data with a one-cycle response strobe. It obeys the register file's rules: one write per cycle, via port 1 only, and reads are performed only in cycles with no write enable. Reads are protected from starvation by a bounded write streak.

---
 rtl/rf_access_sched_pkg.sv | 21 ++
 rtl/rf_access_sched_rr_arbiter4.sv | 28 ++
 rtl/rf_access_sched.sv | 130 +++++++++++++
 tb/tb_rf_access_sched.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_access_sched_pkg.sv
// Shared constants and cycle-type enum for the register-file access scheduler.
// Ports: none (package only).
package rf_access_sched_pkg;

   localparam int RF_DEPTH    = 32;
   localparam int RF_ADDR_W   = 5;
   localparam int RF_DATA_W   = 64;
   localparam int RF_RD_PORTS = 4;

   typedef enum logic [1:0] {
      CYC_IDLE  = 2'd0,
      CYC_WRITE = 2'd1,
      CYC_READ  = 2'd2
   } cyc_t;

   // Width able to hold 0..n inclusive.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rf_access_sched_rr_arbiter4.sv
// Four-way round-robin arbiter: first set request at or above ptr (mod 4).
// Ports: req (requests), ptr (search start) -> gnt (one-hot), idx, any.
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] gnt,
   output logic [1:0] idx,
   output logic       any
);

   logic [1:0] j;

   // Scan from the farthest offset down so the nearest hit wins.
   always_comb begin
      gnt = '0;
      idx = ptr;
      j   = ptr;
      any = |req;
      for (int k = 3; k >= 0; k--) begin
         j = ptr + 2'(k);
         if (req[j]) begin
            idx = j;
         end
      end
      gnt[idx] = any;
   end

endmodule

// File: rtl/rf_access_sched.sv
// Shares a 2W/4R register file among four requesters: one write per
// cycle on port 1, reads only in write-free cycles, bounded write streak.
// Ports:
//   clk, reset               clock, async active-high reset
//   req_valid/we/addr/wdata  per-requester request bundle
//   req_ready                grant (transfer on valid & ready)
//   rsp_valid/rsp_rdata      read response, one cycle after grant
//   rf_r/rf_rp               register-file read enables / addresses
//   rf_w1/rf_w1p/rf_ip1      write port 1 controls
//   rf_w2/rf_w2p/rf_ip2      write port 2 controls (unused, tied 0)
//   rf_op                    register-file read outputs op1..op4
module rf_access_sched
   import rf_access_sched_pkg::*;
#(
   parameter int NUM_REQ      = RF_RD_PORTS,
   parameter int ADDR_W       = RF_ADDR_W,
   parameter int DATA_W       = RF_DATA_W,
   parameter int WR_BURST_MAX = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [NUM_REQ*DATA_W-1:0] rsp_rdata,
   output logic [3:0]                rf_r,
   output logic [4*ADDR_W-1:0]       rf_rp,
   output logic                      rf_w1,
   output logic                      rf_w2,
   output logic [ADDR_W-1:0]         rf_w1p,
   output logic [ADDR_W-1:0]         rf_w2p,
   output logic [DATA_W-1:0]         rf_ip1,
   output logic [DATA_W-1:0]         rf_ip2,
   input  logic [4*DATA_W-1:0]       rf_op
);

   localparam int SW = cnt_w(WR_BURST_MAX);
   localparam logic [SW-1:0] SMAX = SW'(WR_BURST_MAX);

   logic [NUM_REQ-1:0] wr_req;
   logic [NUM_REQ-1:0] rd_req;
   logic [1:0]         rr_ptr;
   logic [SW-1:0]      wr_streak;
   logic [3:0]         wr_gnt;
   logic [1:0]         wr_win;
   logic               wr_any;
   cyc_t               cyc;

   assign wr_req = req_valid & req_we;
   assign rd_req = req_valid & ~req_we;

   rr_arbiter4 u_arb (
      .req (wr_req),
      .ptr (rr_ptr),
      .gnt (wr_gnt),
      .idx (wr_win),
      .any (wr_any)
   );

   // Writes win unless reads are waiting and the streak is exhausted.
   always_comb begin
      cyc = CYC_IDLE;
      if (reset) begin
         cyc = CYC_IDLE;
      end else if (wr_any &&
                   (rd_req == '0 || wr_streak < SMAX)) begin
         cyc = CYC_WRITE;
      end else if (|rd_req) begin
         cyc = CYC_READ;
      end
   end

   always_comb begin
      req_ready = '0;
      rf_r      = '0;
      rf_rp     = '0;
      rf_w1     = 1'b0;
      rf_w1p    = '0;
      rf_ip1    = '0;
      unique case (cyc)
         CYC_WRITE: begin
            rf_w1     = 1'b1;
            rf_w1p    = req_addr[wr_win*ADDR_W +: ADDR_W];
            rf_ip1    = req_wdata[wr_win*DATA_W +: DATA_W];
            req_ready = wr_gnt;
         end
         CYC_READ: begin
            rf_r      = rd_req;
            req_ready = rd_req;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (rd_req[i]) begin
                  rf_rp[i*ADDR_W +: ADDR_W] =
                     req_addr[i*ADDR_W +: ADDR_W];
               end
            end
         end
         default: begin
         end
      endcase
   end

   assign rf_w2     = 1'b0;
   assign rf_w2p    = '0;
   assign rf_ip2    = '0;
   // The register file registers op at the grant edge, so the
   // pass-through lines up with the registered strobe.
   assign rsp_rdata = rf_op;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr    <= '0;
         wr_streak <= '0;
         rsp_valid <= '0;
      end else begin
         rsp_valid <= (cyc == CYC_READ) ? rd_req : '0;
         if (cyc == CYC_WRITE) begin
            rr_ptr <= wr_win + 2'd1;
            if (wr_streak != SMAX) begin
               wr_streak <= wr_streak + 1'b1;
            end
         end else begin
            wr_streak <= '0;
         end
      end
   end

endmodule

// File: tb/tb_rf_access_sched.sv
// Bench for rf_access_sched: register-file model plus a rule-level
// scheduler model, directed scenarios followed by random traffic.
module tb_rf_access_sched;

   logic         clk;
   logic         reset;
   logic [3:0]   req_valid;
   logic [3:0]   req_we;
   logic [19:0]  req_addr;
   logic [255:0] req_wdata;
   logic [3:0]   req_ready;
   logic [3:0]   rsp_valid;
   logic [255:0] rsp_rdata;
   logic [3:0]   rf_r;
   logic [19:0]  rf_rp;
   logic         rf_w1;
   logic         rf_w2;
   logic [4:0]   rf_w1p;
   logic [4:0]   rf_w2p;
   logic [63:0]  rf_ip1;
   logic [63:0]  rf_ip2;
   logic [255:0] rf_op;

   logic [3:0]   v;
   logic [3:0]   we;
   logic [4:0]   a [4];
   logic [63:0]  d [4];

   logic [63:0]  rf_mem [32];
   logic [63:0]  m_mem [32];
   int           m_ptr;
   int           m_streak;
   logic [3:0]   g_ready;
   int           ncmp;
   int           nfail;

   rf_access_sched dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rf_r      (rf_r),
      .rf_rp     (rf_rp),
      .rf_w1     (rf_w1),
      .rf_w2     (rf_w2),
      .rf_w1p    (rf_w1p),
      .rf_w2p    (rf_w2p),
      .rf_ip1    (rf_ip1),
      .rf_ip2    (rf_ip2),
      .rf_op     (rf_op)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      req_valid = v;
      req_we    = we;
      for (int i = 0; i < 4; i++) begin
         req_addr[i*5 +: 5]    = a[i];
         req_wdata[i*64 +: 64] = d[i];
      end
   end

   // Register file: write-through on port 1, registered read outputs.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
         rf_op <= '0;
      end else begin
         if (rf_w1) rf_mem[rf_w1p] <= rf_ip1;
         for (int i = 0; i < 4; i++) begin
            if (rf_r[i]) rf_op[i*64 +: 64] <= rf_mem[rf_rp[i*5 +: 5]];
         end
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr    = 0;
      m_streak = 0;
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
   endtask

   // Called at a negedge with reset high already set by caller.
   task automatic reset_checks();
      #1;
      chk("rst_rsp_valid", {252'd0, rsp_valid}, 0);
      chk("rst_ready", {252'd0, req_ready}, 0);
      chk("rst_w1", {255'd0, rf_w1}, 0);
      chk("rst_r", {252'd0, rf_r}, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // One scheduler cycle: predict grants from the rules, check, clock,
   // then check the response. Starts and ends at a negedge.
   task automatic run_cycle();
      logic [3:0]  wr, rd, e_rdy, e_r, e_rsp;
      logic [19:0] e_rp;
      logic        e_w1;
      logic [4:0]  e_w1p;
      logic [63:0] e_ip;
      int          win;
      wr = v & we;
      rd = v & ~we;
      e_rdy = '0; e_r = '0; e_rp = '0;
      e_w1 = 1'b0; e_w1p = '0; e_ip = '0;
      win = -1;
      if (wr != 0 && (rd == 0 || m_streak < 4)) begin
         for (int k = 0; k < 4; k++) begin
            if (win < 0 && wr[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
         end
         e_w1 = 1'b1;
         e_w1p = a[win];
         e_ip = d[win];
         e_rdy[win] = 1'b1;
      end else if (rd != 0) begin
         e_r = rd;
         e_rdy = rd;
         for (int i = 0; i < 4; i++) begin
            if (rd[i]) e_rp[i*5 +: 5] = a[i];
         end
      end
      #1;
      chk("ready", {252'd0, req_ready}, {252'd0, e_rdy});
      chk("w1", {255'd0, rf_w1}, {255'd0, e_w1});
      chk("w1p", {251'd0, rf_w1p}, {251'd0, e_w1p});
      chk("ip1", {192'd0, rf_ip1}, {192'd0, e_ip});
      chk("r", {252'd0, rf_r}, {252'd0, e_r});
      chk("rp", {236'd0, rf_rp}, {236'd0, e_rp});
      chk("w2", {255'd0, rf_w2}, 0);
      chk("excl", {255'd0, rf_w1 & (|rf_r)}, 0);
      g_ready = e_rdy;
      @(posedge clk);
      e_rsp = '0;
      if (win >= 0) begin
         m_mem[a[win]] = d[win];
         m_ptr = (win + 1) % 4;
         if (m_streak < 4) m_streak++;
      end else begin
         m_streak = 0;
         e_rsp = rd;
      end
      #1;
      chk("rsp_valid", {252'd0, rsp_valid}, {252'd0, e_rsp});
      for (int i = 0; i < 4; i++) begin
         if (e_rsp[i]) begin
            chk("rdata", {192'd0, rsp_rdata[i*64 +: 64]},
                {192'd0, m_mem[a[i]]});
         end
      end
      @(negedge clk);
   endtask

   task automatic new_req(input int i);
      v[i]  = 1'b1;
      we[i] = 1'($urandom_range(0, 1));
      a[i]  = 5'($urandom_range(0, 7));
      d[i]  = {$urandom, $urandom};
   endtask

   initial begin
      int n;
      logic got;
      ncmp = 0;
      nfail = 0;
      v = '0;
      we = '0;
      g_ready = '0;
      for (int i = 0; i < 4; i++) begin
         a[i] = '0;
         d[i] = '0;
      end
      model_reset();

      // Reset with live requests: nothing may be granted.
      reset = 1'b1;
      v = 4'b1111;
      we = 4'b0101;
      @(negedge clk);
      reset_checks();
      v = '0;

      // Write 100 to r0, then read it back.
      v[0] = 1'b1; we[0] = 1'b1; a[0] = 5'd0; d[0] = 64'd100;
      run_cycle();
      chk("t1_wgrant", {252'd0, g_ready}, 1);
      we[0] = 1'b0;
      run_cycle();
      chk("t1_rvalid", {255'd0, rsp_valid[0]}, 1);
      chk("t1_rdata", {192'd0, rsp_rdata[63:0]}, 100);
      v = '0;

      // Four simultaneous writes rotate 0..3, then one 4-way read.
      reset = 1'b1;
      @(negedge clk);
      reset_checks();
      for (int i = 0; i < 4; i++) begin
         v[i] = 1'b1; we[i] = 1'b1;
         a[i] = 5'(i); d[i] = 64'(100 * (i + 1));
      end
      for (int k = 0; k < 4; k++) begin
         run_cycle();
         chk("t2_order", {252'd0, g_ready}, 256'(1 << k));
         v[k] = 1'b0;
      end
      v = 4'b1111;
      we = 4'b0000;
      run_cycle();
      chk("t2_rvalid", {252'd0, rsp_valid}, 4'b1111);
      for (int i = 0; i < 4; i++) begin
         chk("t2_rdata", {192'd0, rsp_rdata[i*64 +: 64]},
             256'(100 * (i + 1)));
      end
      v = '0;

      // Write stream on 1 against a held read on 2: read in cycle 5.
      v[1] = 1'b1; we[1] = 1'b1; a[1] = 5'd9; d[1] = 64'h500;
      v[2] = 1'b1; we[2] = 1'b0; a[2] = 5'd5;
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         run_cycle();
         n++;
         if (g_ready[2]) got = 1'b1;
         else if (g_ready[1]) d[1] = d[1] + 64'd1;
      end
      chk("t3_cycles", 256'(n), 5);
      v = '0;

      // Same-address write and read: write first, read sees 600.
      v[3] = 1'b1; we[3] = 1'b1; a[3] = 5'd7; d[3] = 64'd600;
      v[0] = 1'b1; we[0] = 1'b0; a[0] = 5'd7;
      run_cycle();
      chk("t4_wfirst", {252'd0, g_ready}, 4'b1000);
      v[3] = 1'b0;
      run_cycle();
      chk("t4_rgrant", {252'd0, g_ready}, 4'b0001);
      chk("t4_rdata", {192'd0, rsp_rdata[63:0]}, 600);
      v = '0;

      // Reset right after a read grant drops the response.
      v[0] = 1'b1; we[0] = 1'b0; a[0] = 5'd2;
      run_cycle();
      chk("t5_pre", {255'd0, rsp_valid[0]}, 1);
      reset = 1'b1;
      reset_checks();
      a[0] = 5'd2;
      run_cycle();
      chk("t5_cleared", {192'd0, rsp_rdata[63:0]}, 0);
      v = '0;

      // Requesters 0 and 2 contend: strict alternation from ptr 0.
      v[0] = 1'b1; we[0] = 1'b1; a[0] = 5'd10; d[0] = 64'h1000;
      v[2] = 1'b1; we[2] = 1'b1; a[2] = 5'd12; d[2] = 64'h2000;
      for (int k = 0; k < 8; k++) begin
         run_cycle();
         chk("t6_alt", {252'd0, g_ready},
             (k % 2 == 0) ? 256'd1 : 256'd4);
         d[0] = d[0] + 64'd1;
         d[2] = d[2] + 64'd1;
      end
      v = '0;

      // Random traffic against the rule model.
      for (int c = 0; c < 400; c++) begin
         run_cycle();
         for (int i = 0; i < 4; i++) begin
            if (v[i] && g_ready[i]) begin
               if ($urandom_range(0, 4) != 0) new_req(i);
               else v[i] = 1'b0;
            end else if (!v[i] && $urandom_range(0, 2) == 0) begin
               new_req(i);
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nfail);
      $finish;
   end

endmodule
